// File: rtl/shift8_sipo.sv
// ---------------------------------------------------------------------------
// shift8_sipo
//   Serial-in / parallel-out shift register with parallel load, serial tap-out
//   and a "word complete" flag. Bits enter MSB-first: after WIDTH shifts the
//   parallel word appears in its original bit order.
//
// Parameters
//   WIDTH       register width in bits (2..32), default 8
//   ODD_PARITY  (only with SHIFT8_PARITY_EN) 1 inverts the parity output
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   data_in     serial data bit, sampled on rising clk
//   shift_en    shift enable
//   load        synchronous parallel load strobe (wins over shift_en)
//   load_data   parallel load value
//   result      current register contents (registered)
//   serial_out  bit about to be shifted out, equal to result[WIDTH-1]
//   full        high once WIDTH shifts have completed since reset/load
//   parity      (only with SHIFT8_PARITY_EN) XOR of all result bits
//
// Optional feature macro: SHIFT8_PARITY_EN
// ---------------------------------------------------------------------------
module shift8_sipo #(
    parameter int WIDTH = 8
`ifdef SHIFT8_PARITY_EN
    ,
    parameter bit ODD_PARITY = 1'b0
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             shift_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] result,
    output logic             serial_out,
    output logic             full
`ifdef SHIFT8_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Counter must be able to hold the value WIDTH itself (saturation point).
    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("shift8_sipo: WIDTH must be in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             full_reg;
    logic             full_next;

    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        full_next  = full_reg;
        if (load) begin
            // Load restarts word assembly; data_in is ignored this cycle.
            shift_next = load_data;
            cnt_next   = '0;
            full_next  = 1'b0;
        end else if (shift_en) begin
            shift_next = {shift_reg[WIDTH-2:0], data_in};
            // Saturate so that continued shifting acts as a sliding window
            // and full stays asserted.
            cnt_next   = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);
            full_next  = (cnt_next == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            full_reg  <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            full_reg  <= full_next;
        end
    end

    assign result     = shift_reg;
    assign serial_out = shift_reg[WIDTH-1];
    assign full       = full_reg;

`ifdef SHIFT8_PARITY_EN
    // XOR chain seeded with ODD_PARITY so the inversion folds into the tree.
    logic [WIDTH:0] parity_chain;
    assign parity_chain[0] = ODD_PARITY;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_parity
            assign parity_chain[gi+1] = parity_chain[gi] ^ shift_reg[gi];
        end
    endgenerate
    assign parity = parity_chain[WIDTH];
`endif

endmodule

// File: tb/tb_shift8_sipo.sv
// ---------------------------------------------------------------------------
// tb_shift8_sipo
//   Self-checking bench for shift8_sipo (WIDTH = 8). Directed test-plan steps
//   followed by randomized shift/hold/load/reset traffic, all compared against
//   an arithmetic model: the word is (value * 2 + bit) mod 2^WIDTH and the
//   completion flag is "at least WIDTH shifts since reset/load".
// ---------------------------------------------------------------------------
module tb_shift8_sipo;

    localparam int W = 8;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         data_in = 1'b0;
    logic         shift_en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_data = '0;
    logic [W-1:0] result;
    logic         serial_out;
    logic         full;
`ifdef SHIFT8_PARITY_EN
    logic         parity;
`endif

    shift8_sipo #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .shift_en   (shift_en),
        .load       (load),
        .load_data  (load_data),
        .result     (result),
        .serial_out (serial_out),
        .full       (full)
`ifdef SHIFT8_PARITY_EN
        ,
        .parity     (parity)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    longint unsigned model_val = 0;
    int              model_shifts = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_value({tag, ".result"}, 32'(result), 32'(model_val));
        check_value({tag, ".full"}, 32'(full), 32'(model_shifts >= W));
        check_value({tag, ".serial_out"}, 32'(serial_out), 32'((model_val >> (W - 1)) & 1));
`ifdef SHIFT8_PARITY_EN
        check_value({tag, ".parity"}, 32'(parity), 32'($countones(model_val) % 2));
`endif
    endtask

    // One clock transaction: drive at the falling edge, let the rising edge
    // act, then compare at the next falling edge.
    task automatic do_cycle(input string tag, input logic sh, input logic ld,
                            input logic [W-1:0] ldd, input logic din);
        shift_en  = sh;
        load      = ld;
        load_data = ldd;
        data_in   = din;
        @(posedge clk);
        if (ld) begin
            model_val    = longint'(ldd);
            model_shifts = 0;
        end else if (sh) begin
            model_val    = ((model_val * 2) + longint'(din)) & MASK;
            model_shifts = model_shifts + 1;
        end
        @(negedge clk);
        $display("[%0t] %s sh=%0b ld=%0b ldd=%h din=%0b -> result=%h full=%0b so=%0b",
                 $time, tag, sh, ld, ldd, din, result, full, serial_out);
        check_all(tag);
    endtask

    // Assert reset between clock edges, check immediately, release at the
    // following falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_val    = 0;
        model_shifts = 0;
        $display("[%0t] %s async reset asserted -> result=%h full=%0b", $time, tag, result, full);
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] word;
        logic [W-1:0] basic_exp [0:7];
        basic_exp = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1D, 8'h3A, 8'h75, 8'h75};
        basic_exp[0] = 8'h00;
        basic_exp[1] = 8'h01;
        basic_exp[2] = 8'h03;
        basic_exp[3] = 8'h07;
        basic_exp[4] = 8'h0E;
        basic_exp[5] = 8'h1D;
        basic_exp[6] = 8'h3A;
        basic_exp[7] = 8'h75;

        // Reset state
        @(negedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic word assembly, MSB-first 8'b01110101
        word = 8'b0111_0101;
        check_all("basic.edge0");
        for (int i = 0; i < W; i++) begin
            do_cycle("basic", 1'b1, 1'b0, '0, word[W-1-i]);
            check_value("basic.table", 32'(result), 32'(basic_exp[i]));
            check_value("basic.full_edge", 32'(full), 32'(i == W - 1));
        end

        // Async reset after a load
        do_cycle("areset.load", 1'b0, 1'b1, 8'hA5, 1'b0);
        async_reset("areset");
        check_value("areset.result", 32'(result), 32'h00);
        do_cycle("areset.shift1", 1'b1, 1'b0, '0, 1'b1);
        check_value("areset.after", 32'(result), 32'h01);

        // Hold: counter frozen, proven by full timing afterwards
        do_cycle("hold.load", 1'b0, 1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_cycle("hold", 1'b0, 1'b0, 8'hFF, 1'(i % 2));
            check_value("hold.result", 32'(result), 32'h3C);
        end
        for (int i = 0; i < W; i++) begin
            do_cycle("hold.refill", 1'b1, 1'b0, '0, 1'b0);
            check_value("hold.full_timing", 32'(full), 32'(i == W - 1));
        end

        // Overflow / sliding window: 10 ones then a zero
        async_reset("ovf.reset");
        for (int i = 0; i < 11; i++) begin
            do_cycle("ovf", 1'b1, 1'b0, '0, 1'(i < 10));
            check_value("ovf.full", 32'(full), 32'(i >= W - 1));
        end
        check_value("ovf.final", 32'(result), 32'hFE);
        check_value("ovf.serial_out", 32'(serial_out), 32'h1);

        // Load priority over shift while full
        do_cycle("loadprio", 1'b1, 1'b1, 8'hC3, 1'b1);
        check_value("loadprio.result", 32'(result), 32'hC3);
        check_value("loadprio.full", 32'(full), 32'h0);
        check_value("loadprio.serial_out", 32'(serial_out), 32'h1);

`ifdef SHIFT8_PARITY_EN
        do_cycle("parity.load", 1'b0, 1'b1, 8'h07, 1'b0);
        check_value("parity.07", 32'(parity), 32'h1);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                async_reset("rand.reset");
            end else if (r < 8) begin
                do_cycle("rand.load", 1'($urandom_range(0, 1)), 1'b1,
                         W'($urandom()), 1'($urandom_range(0, 1)));
            end else if (r < 25) begin
                do_cycle("rand.hold", 1'b0, 1'b0, W'($urandom()), 1'($urandom_range(0, 1)));
            end else begin
                do_cycle("rand.shift", 1'b1, 1'b0, W'($urandom()), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
